gate_stim_checker: RTL

Self-checking stimulus stage that sits directly upstream of a 2-input gate under test (nor_gate and its siblings). It drives the gate's A/B inputs through all four input vectors and samples the gate's Y output after a programmable settle time. It compares each sample against the expected truth table and reports per-vector mismatches, an error count and a pass flag. This replaces open-loop, delay-based test vectors with a clocked, reusable checker.

---
 rtl/gate_stim_checker.sv | 107 ++++++++++
 1 files changed

// File: rtl/gate_stim_checker.sv
// Clocked stimulus/checker for a 2-input gate under test: walks A/B through all
// four vectors, samples Y after a settle period and accumulates mismatches.
module gate_stim_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  output logic             A,
  output logic             B,
  input  logic             Y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       err_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t           state;
  logic [1:0]       vec;
  logic [3:0]       settle_cnt;
  logic [2:0]       sel_q;
  logic             expected_y;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  // Reserved selector codes fall back to NOR.
  always_comb begin
    expected_y = ~(A | B);
    case (sel_q)
      3'd0:    expected_y = A & B;
      3'd1:    expected_y = A | B;
      3'd2:    expected_y = ~(A & B);
      3'd3:    expected_y = ~(A | B);
      3'd4:    expected_y = A ^ B;
      3'd5:    expected_y = ~(A ^ B);
      default: expected_y = ~(A | B);
    endcase
  end

  assign mismatch = (Y != expected_y);
  assign err_next = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + ERR_W'(1) : err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= 2'd0;
      settle_cnt <= 4'd0;
      sel_q      <= 3'd0;
      A          <= 1'b0;
      B          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      err_vec    <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sel_q      <= gate_sel;
            err_cnt    <= '0;
            err_vec    <= 4'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec        <= 2'd0;
            A          <= 1'b0;
            B          <= 1'b0;
            busy       <= 1'b1;
            settle_cnt <= 4'd0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (settle_cnt == SETTLE_LAST) begin
            err_cnt <= err_next;
            if (mismatch) err_vec[vec] <= 1'b1;
            // pass must already reflect the last vector's result on this edge.
            if (vec == 2'd3) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              A     <= 1'b0;
              B     <= 1'b0;
              pass  <= (err_next == '0);
            end else begin
              vec        <= vec + 2'd1;
              {A, B}     <= vec + 2'd1;
              settle_cnt <= 4'd0;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
